// File: rtl/lsu_issue_queue.sv
// In-order LSU request queue: holds issued requests and presents the oldest one
// to the load or store unit by class, with a zero-latency bypass when empty.
package lsu_pkg;
    typedef struct packed {
        logic [3:0]  trans_id;
        logic [1:0]  size;
        logic [31:0] vaddr;
        logic [31:0] wdata;
    } lsu_ctrl_t;
endpackage

// Handshakes: issue side transfers when valid_i & ready_o & !flush_i; unit side
// retires the head when pop_ld_i & ld_valid_o or pop_st_i & st_valid_o.
module lsu_issue_queue
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH            = 2,
    parameter int unsigned CNT_W            = $clog2(DEPTH + 1),
    parameter bit          ASSERT_STRAY_POP = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  lsu_ctrl_t        lsu_ctrl_i,
    input  logic             is_store_i,
    output logic             ready_o,
    output lsu_ctrl_t        lsu_ctrl_o,
    output logic             ld_valid_o,
    output logic             st_valid_o,
    input  logic             pop_ld_i,
    input  logic             pop_st_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    lsu_ctrl_t        mem_q [DEPTH];
    lsu_ctrl_t        mem_d [DEPTH];
    logic [DEPTH-1:0] cls_q, cls_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stored;
    logic push;
    logic pop;
    logic head_valid;
    logic head_cls;
    logic do_write;
    logic do_retire;

    // A same-cycle pop never frees a slot for this cycle's push: ready depends on count only.
    always_comb begin
        stored     = (cnt_q != '0);
        ready_o    = (cnt_q != CNT_W'(DEPTH));
        push       = valid_i & ready_o & ~flush_i;
        head_valid = stored | (valid_i & ~flush_i);
        head_cls   = stored ? cls_q[rd_ptr_q] : is_store_i;
        ld_valid_o = head_valid & ~head_cls & ~flush_i & ~rst_i;
        st_valid_o = head_valid &  head_cls & ~flush_i & ~rst_i;
        lsu_ctrl_o = rst_i ? '0 : (stored ? mem_q[rd_ptr_q] : lsu_ctrl_i);
        pop        = (pop_ld_i & ld_valid_o) | (pop_st_i & st_valid_o);
        count_o    = cnt_q;
        empty_o    = ~stored;
    end

    // With an empty queue a pop can only target the bypassed request, which then never lands.
    always_comb begin
        do_write  = push & ~(pop & ~stored);
        do_retire = pop & stored;
        mem_d     = mem_q;
        cls_d     = cls_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_write) begin
                mem_d[wr_ptr_q] = lsu_ctrl_i;
                cls_d[wr_ptr_q] = is_store_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_retire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_write) - CNT_W'(do_retire);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset: it is only read once count marks it valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        cls_q <= cls_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(pop_ld_i && pop_st_i));
            assert (cnt_q <= CNT_W'(DEPTH));
            if (ASSERT_STRAY_POP && !flush_i) begin
                assert (!(pop_ld_i && !ld_valid_o) && !(pop_st_i && !st_valid_o));
            end
        end
    end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_lsu_issue_queue;
    import lsu_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = $bits(lsu_ctrl_t) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             valid_i;
    lsu_ctrl_t        lsu_ctrl_i;
    logic             is_store_i;
    logic             ready_o;
    lsu_ctrl_t        lsu_ctrl_o;
    logic             ld_valid_o;
    logic             st_valid_o;
    logic             pop_ld_i;
    logic             pop_st_i;
    logic [CNT_W-1:0] count_o;
    logic             empty_o;

    int errors = 0;
    int checks = 0;
    logic [ENT_W-1:0] exp_q[$];

    lsu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ASSERT_STRAY_POP(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .lsu_ctrl_i(lsu_ctrl_i), .is_store_i(is_store_i), .ready_o(ready_o),
        .lsu_ctrl_o(lsu_ctrl_o), .ld_valid_o(ld_valid_o), .st_valid_o(st_valid_o),
        .pop_ld_i(pop_ld_i), .pop_st_i(pop_st_i), .count_o(count_o), .empty_o(empty_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic lsu_ctrl_t mk(input int id);
        lsu_ctrl_t c;
        c.trans_id = 4'(id);
        c.size     = 2'(id);
        c.vaddr    = 32'h8000_0000 + 32'(id * 4);
        c.wdata    = 32'ha5a5_0000 | 32'(id);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        pop_ld_i   = 1'b0;
        pop_st_i   = 1'b0;
        is_store_i = 1'b0;
        lsu_ctrl_i = '0;
    endtask

    task automatic req(input int id, input logic st);
        valid_i    = 1'b1;
        is_store_i = st;
        lsu_ctrl_i = mk(id);
    endtask

    // ---------------- scoreboard: model compare every cycle ----------------
    always @(negedge clk_i) begin
        int        sz;
        logic      hv, hc, e_ld, e_st, popa, pushm;
        lsu_ctrl_t ec;
        if (rst_i) begin
            exp_q.delete();
            chk("m_rst_ready", 128'(ready_o), 128'(1));
            chk("m_rst_ld", 128'(ld_valid_o), 128'(0));
            chk("m_rst_st", 128'(st_valid_o), 128'(0));
            chk("m_rst_cnt", 128'(count_o), 128'(0));
            chk("m_rst_empty", 128'(empty_o), 128'(1));
            chk("m_rst_ctrl", 128'(lsu_ctrl_o), 128'(0));
        end else begin
            sz   = exp_q.size();
            hv   = (sz > 0) || (valid_i && !flush_i);
            hc   = (sz > 0) ? exp_q[0][ENT_W-1] : is_store_i;
            e_ld = hv && !hc && !flush_i;
            e_st = hv && hc && !flush_i;
            ec   = (sz > 0) ? exp_q[0][ENT_W-2:0] : lsu_ctrl_i;
            chk("m_ready", 128'(ready_o), 128'(sz < DEPTH));
            chk("m_count", 128'(count_o), 128'(sz));
            chk("m_empty", 128'(empty_o), 128'(sz == 0));
            chk("m_ld_valid", 128'(ld_valid_o), 128'(e_ld));
            chk("m_st_valid", 128'(st_valid_o), 128'(e_st));
            chk("m_ctrl", 128'(lsu_ctrl_o), 128'(ec));
            popa  = (pop_ld_i && e_ld) || (pop_st_i && e_st);
            pushm = valid_i && (sz < DEPTH) && !flush_i;
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (popa && sz > 0) void'(exp_q.pop_front());
                if (pushm && !(popa && sz == 0)) exp_q.push_back({is_store_i, lsu_ctrl_i});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        chk("init_count", 128'(count_o), 128'(0));
        chk("init_ready", 128'(ready_o), 128'(1));

        // Bypass: empty queue, store id 5 consumed in the same cycle.
        tick();
        req(5, 1'b1);
        pop_st_i = 1'b1;
        #1;
        chk("byp_st_valid", 128'(st_valid_o), 128'(1));
        chk("byp_ld_valid", 128'(ld_valid_o), 128'(0));
        chk("byp_id", 128'(lsu_ctrl_o.trans_id), 128'(5));
        tick();
        idle();
        #1;
        chk("byp_count", 128'(count_o), 128'(0));
        chk("byp_empty", 128'(empty_o), 128'(1));

        // Ordering: store 1 then load 2; stray load pops while the store is at the head.
        tick();
        req(1, 1'b1);
        tick();
        req(2, 1'b0);
        pop_ld_i = 1'b1;
        #1;
        chk("ord_cnt1", 128'(count_o), 128'(1));
        chk("ord_head1", 128'(lsu_ctrl_o.trans_id), 128'(1));
        tick();
        idle();
        pop_ld_i = 1'b1;
        #1;
        chk("ord_cnt2", 128'(count_o), 128'(2));
        chk("ord_ready", 128'(ready_o), 128'(0));
        chk("ord_st_valid", 128'(st_valid_o), 128'(1));
        chk("ord_ld_hidden", 128'(ld_valid_o), 128'(0));
        chk("ord_head_id", 128'(lsu_ctrl_o.trans_id), 128'(1));
        tick();
        pop_ld_i = 1'b0;
        pop_st_i = 1'b1;
        #1;
        chk("ord_stray_cnt", 128'(count_o), 128'(2));
        tick();
        idle();
        #1;
        chk("ord_ld_valid", 128'(ld_valid_o), 128'(1));
        chk("ord_st_gone", 128'(st_valid_o), 128'(0));
        chk("ord_id2", 128'(lsu_ctrl_o.trans_id), 128'(2));
        chk("ord_cnt3", 128'(count_o), 128'(1));

        // Full: fill with store 3, then push load 4 while popping the load head.
        req(3, 1'b1);
        tick();
        req(4, 1'b0);
        pop_ld_i = 1'b1;
        #1;
        chk("full_ready", 128'(ready_o), 128'(0));
        chk("full_head", 128'(lsu_ctrl_o.trans_id), 128'(2));
        tick();
        pop_ld_i = 1'b0;
        #1;
        chk("full_cnt_drop", 128'(count_o), 128'(1));
        chk("full_head3", 128'(lsu_ctrl_o.trans_id), 128'(3));
        chk("full_ready2", 128'(ready_o), 128'(1));
        tick();
        idle();
        #1;
        chk("full_accept", 128'(count_o), 128'(2));
        pop_st_i = 1'b1;
        tick();
        idle();
        #1;
        chk("full_id4", 128'(lsu_ctrl_o.trans_id), 128'(4));
        chk("full_id4_ld", 128'(ld_valid_o), 128'(1));
        pop_ld_i = 1'b1;
        tick();
        idle();
        #1;
        chk("full_drained", 128'(count_o), 128'(0));

        // Wrap-around: 10 push/pop pairs, alternating class.
        for (int i = 0; i < 10; i++) begin
            req(i, 1'(i % 2));
            tick();
            idle();
            if (i % 2 == 1) pop_st_i = 1'b1;
            else pop_ld_i = 1'b1;
            #1;
            chk("wrap_id", 128'(lsu_ctrl_o.trans_id), 128'(i));
            chk("wrap_cnt", 128'(count_o), 128'(1));
            tick();
            idle();
        end
        #1;
        chk("wrap_end_cnt", 128'(count_o), 128'(0));

        // Flush: two entries queued, flush with a push and a pop pending.
        req(6, 1'b1);
        tick();
        req(7, 1'b0);
        tick();
        req(8, 1'b0);
        flush_i  = 1'b1;
        pop_st_i = 1'b1;
        #1;
        chk("fl_st", 128'(st_valid_o), 128'(0));
        chk("fl_ld", 128'(ld_valid_o), 128'(0));
        chk("fl_cnt_before", 128'(count_o), 128'(2));
        tick();
        idle();
        #1;
        chk("fl_cnt", 128'(count_o), 128'(0));
        chk("fl_empty", 128'(empty_o), 128'(1));
        chk("fl_st_after", 128'(st_valid_o), 128'(0));

        // Asynchronous reset mid-cycle with two entries queued and a request pending.
        req(10, 1'b0);
        tick();
        req(11, 1'b1);
        tick();
        req(12, 1'b0);
        #2;
        chk("pre_rst_cnt", 128'(count_o), 128'(2));
        rst_i = 1'b1;
        #1;
        chk("rst_cnt", 128'(count_o), 128'(0));
        chk("rst_empty", 128'(empty_o), 128'(1));
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_ld", 128'(ld_valid_o), 128'(0));
        chk("rst_st", 128'(st_valid_o), 128'(0));
        chk("rst_ctrl", 128'(lsu_ctrl_o), 128'(0));
        tick();
        idle();
        rst_i = 1'b0;
        tick();
        #1;
        chk("post_rst_cnt", 128'(count_o), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
